// File: rtl/seven_segment_scanner.sv
// Four-digit common-anode seven-segment scanner with a double-buffered value
// committed at frame boundaries. Optional leading-zero blanking via SEG_LZ_BLANK_EN.
module seven_segment_scanner #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic        cg,
  output logic        cf,
  output logic        ce,
  output logic        cd,
  output logic        cc,
  output logic        cb,
  output logic        ca,
  output logic        dp,
  output logic        busy,
  output logic        frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [15:0]   disp_val;
  logic [3:0]    disp_dp;
  logic [15:0]   pend_val;
  logic [3:0]    pend_dp;
  logic          pend_valid;
  logic [6:0]    seg;

  logic          tick;
  logic          boundary;
  logic [3:0]    nib;
  logic          blank;
  logic [3:0]    next_an;
  logic [6:0]    next_seg;
  logic          next_dp;

  assign tick     = (prescaler == PRESCALE_LAST);
  assign boundary = tick && (idx == 2'd3);
  assign busy     = pend_valid;
  assign {cg, cf, ce, cd, cc, cb, ca} = seg;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nib   = disp_val[{idx, 2'b00} +: 4];
    blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    // A digit goes dark only if it and every digit above it are zero; digit 0 always shows.
    case (idx)
      2'd3:    blank = (disp_val[15:12] == 4'h0);
      2'd2:    blank = (disp_val[15:8]  == 8'h00);
      2'd1:    blank = (disp_val[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
`endif
    next_an  = (digit_en[idx] && !blank) ? ~(4'b0001 << idx) : 4'b1111;
    next_dp  = blank | ~disp_dp[idx];
    next_seg = blank ? 7'h7F : hex_to_seg(nib);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler  <= '0;
      idx        <= 2'd0;
      disp_val   <= 16'h0000;
      disp_dp    <= 4'h0;
      pend_val   <= 16'h0000;
      pend_dp    <= 4'h0;
      pend_valid <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) idx <= idx + 2'd1;
      if (boundary && pend_valid) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      // A load on the commit cycle refills pending; the commit above still sees the old contents.
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= next_an;
      seg        <= next_seg;
      dp         <= next_dp;
      frame_done <= boundary;
    end
  end

endmodule
